mac_unit_vert_seq: RTL and testbench

- Parametrised, self-sequencing successor of the vertical bit-serial sparse MAC.
- Accepts one activation vector, then consumes W_BITS weight-bit column descriptors (LSB first) over a valid/ready stream.
- Accumulates shifted group partial sums, negating the MSB column (two's-complement weights), and presents the result on a valid/ready output.
- Instantiated per PE column in the bit-serial array; control moves from an external column driver into an internal FSM.

---
 rtl/mac_vert_pkg.sv | 20 ++
 rtl/mac_unit_vert_seq_lane_select_group.sv | 33 +++
 rtl/mac_unit_vert_seq.sv | 159 +++++++++++++++
 tb/tb_mac_unit_vert_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mac_vert_pkg.sv
// Shared state encoding and width helpers for the vertical bit-serial sparse MAC.
package mac_vert_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    function automatic int gsum_w(input int dw, input int gs);
        return dw + $clog2(gs);
    endfunction

    // One extra bit: group_sum - lane_sum can exceed the group-sum range
    // when lanes pick the same activation twice.
    function automatic int psum_w(input int dw, input int gs);
        return gsum_w(dw, gs) + 1;
    endfunction

    function automatic int total_w(input int dw, input int gs, input int ng);
        return psum_w(dw, gs) + $clog2(ng);
    endfunction

endpackage

// File: rtl/mac_unit_vert_seq_lane_select_group.sv
// One group's lane muxes, lane sum and skip-zero complement (combinational).
module lane_select_group
    import mac_vert_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int GROUP_SIZE = 8,
    parameter int SEL_WIDTH  = 3,
    localparam int LANES     = GROUP_SIZE / 2,
    localparam int GSW       = gsum_w(DATA_WIDTH, GROUP_SIZE),
    localparam int PSW       = psum_w(DATA_WIDTH, GROUP_SIZE)
) (
    input  logic [GROUP_SIZE-1:0][DATA_WIDTH-1:0] i_act,
    input  logic signed [GSW-1:0]                 i_group_sum,
    input  logic [LANES-1:0][SEL_WIDTH-1:0]       i_sel,
    input  logic [LANES-1:0]                      i_val,
    input  logic                                  i_skip_zero,
    output logic signed [PSW-1:0]                 o_psum
);

    logic signed [GSW-1:0] w_lane_sum;

    always_comb begin
        w_lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            if (i_val[k] && (i_sel[k] <= SEL_WIDTH'(LANES)))
                w_lane_sum = w_lane_sum + GSW'(signed'(i_act[k + int'(i_sel[k])]));
        end
    end

    assign o_psum = i_skip_zero ? PSW'(w_lane_sum)
                                : PSW'(i_group_sum) - PSW'(w_lane_sum);

endmodule

// File: rtl/mac_unit_vert_seq.sv
// Self-sequencing vertical bit-serial sparse MAC: one activation vector, W_BITS columns LSB first.
// Optional MAC_VERT_SEQ_ROUND_EN: round-and-saturate the result instead of truncating.
module mac_unit_vert_seq
    import mac_vert_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int VEC_LENGTH   = 16,
    parameter int GROUP_SIZE   = 8,
    parameter int W_BITS       = 8,
    localparam int NUM_GROUPS  = VEC_LENGTH / GROUP_SIZE,
    localparam int LANES       = GROUP_SIZE / 2,
    localparam int SEL_WIDTH   = $clog2(LANES + 1),
    localparam int ACC_WIDTH   = DATA_WIDTH + W_BITS + $clog2(VEC_LENGTH),
    localparam int RESULT_WIDTH = 2 * DATA_WIDTH
) (
    input  logic                                          i_clk,
    input  logic                                          i_reset,
    input  logic                                          i_in_valid,
    output logic                                          o_in_ready,
    input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]         i_act_in,
    input  logic                                          i_load_accum,
    input  logic [ACC_WIDTH-1:0]                          i_accum_prev,
    input  logic                                          i_col_valid,
    output logic                                          o_col_ready,
    input  logic [NUM_GROUPS*LANES-1:0][SEL_WIDTH-1:0]    i_act_sel,
    input  logic [NUM_GROUPS*LANES-1:0]                   i_act_val,
    input  logic [NUM_GROUPS-1:0]                         i_is_skip_zero,
    output logic                                          o_out_valid,
    input  logic                                          i_out_ready,
    output logic [RESULT_WIDTH-1:0]                       o_result,
    output logic [ACC_WIDTH-1:0]                          o_accum_out
);

    localparam int GSW = gsum_w(DATA_WIDTH, GROUP_SIZE);
    localparam int PSW = psum_w(DATA_WIDTH, GROUP_SIZE);
    localparam int TW  = total_w(DATA_WIDTH, GROUP_SIZE, NUM_GROUPS);
    localparam int CW  = $clog2(W_BITS + 1);

    state_t r_state, w_next;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] r_act;
    logic [NUM_GROUPS-1:0][GSW-1:0]        r_gsum;
    logic [ACC_WIDTH-1:0]                  r_accum;
    logic [CW-1:0]                         r_col;

    logic [NUM_GROUPS-1:0][GSW-1:0]        w_gsum;
    logic [NUM_GROUPS-1:0][PSW-1:0]        w_psum;
    logic signed [TW-1:0]                  w_total;
    logic signed [ACC_WIDTH-1:0]           w_shift;
    logic signed [ACC_WIDTH-1:0]           w_term;
    logic                                  w_last_col;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_in_ready  = 1'b0;
        o_col_ready = 1'b0;
        o_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) w_next = LOAD;
            end
            LOAD: w_next = RUN;
            RUN: begin
                o_col_ready = 1'b1;
                if (i_col_valid && w_last_col) w_next = DONE;
            end
            DONE: begin
                o_out_valid = 1'b1;
                if (i_out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_gsum = '0;
        for (int g = 0; g < NUM_GROUPS; g++)
            for (int i = 0; i < GROUP_SIZE; i++)
                w_gsum[g] = GSW'(signed'(w_gsum[g]) + GSW'(signed'(r_act[g*GROUP_SIZE + i])));
    end

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
        lane_select_group #(
            .DATA_WIDTH (DATA_WIDTH),
            .GROUP_SIZE (GROUP_SIZE),
            .SEL_WIDTH  (SEL_WIDTH)
        ) u_lsg (
            .i_act       (r_act[g*GROUP_SIZE +: GROUP_SIZE]),
            .i_group_sum (r_gsum[g]),
            .i_sel       (i_act_sel[g*LANES +: LANES]),
            .i_val       (i_act_val[g*LANES +: LANES]),
            .i_skip_zero (i_is_skip_zero[g]),
            .o_psum      (w_psum[g])
        );
    end

    always_comb begin
        w_total = '0;
        for (int g = 0; g < NUM_GROUPS; g++)
            w_total = w_total + TW'(signed'(w_psum[g]));
    end

    // MSB column carries negative weight in two's complement.
    assign w_last_col = (r_col == CW'(W_BITS - 1));
    assign w_shift    = ACC_WIDTH'(w_total) <<< r_col;
    assign w_term     = w_last_col ? -w_shift : w_shift;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_act   <= '0;
            r_gsum  <= '0;
            r_accum <= '0;
            r_col   <= '0;
        end else begin
            case (r_state)
                IDLE: if (i_in_valid) begin
                    r_act   <= i_act_in;
                    r_accum <= i_load_accum ? i_accum_prev : '0;
                end
                LOAD: begin
                    r_gsum <= w_gsum;
                    r_col  <= '0;
                end
                RUN: if (i_col_valid) begin
                    r_accum <= r_accum + w_term;
                    r_col   <= r_col + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_accum_out = r_accum;

`ifdef MAC_VERT_SEQ_ROUND_EN
    localparam int SH = ACC_WIDTH - RESULT_WIDTH;
    if (SH > 0) begin : g_rnd
        localparam logic [ACC_WIDTH:0] BIAS = (ACC_WIDTH+1)'(1) << (SH - 1);
        logic [ACC_WIDTH:0]    w_rnd;
        logic [RESULT_WIDTH:0] w_q;
        assign w_rnd = {r_accum[ACC_WIDTH-1], r_accum} + BIAS;
        assign w_q   = w_rnd[ACC_WIDTH -: RESULT_WIDTH+1];
        // Disagreeing top bits mean the rounded value left the signed range.
        assign o_result = (w_q[RESULT_WIDTH] == w_q[RESULT_WIDTH-1]) ? w_q[RESULT_WIDTH-1:0] :
                          w_q[RESULT_WIDTH] ? {1'b1, {(RESULT_WIDTH-1){1'b0}}}
                                            : {1'b0, {(RESULT_WIDTH-1){1'b1}}};
    end else begin : g_trunc
        assign o_result = r_accum[ACC_WIDTH-1 -: RESULT_WIDTH];
    end
`else
    assign o_result = r_accum[ACC_WIDTH-1 -: RESULT_WIDTH];
`endif

endmodule

// File: tb/tb_mac_unit_vert_seq.sv
// Directed table-driven bench for mac_unit_vert_seq (default parameters).
module tb_mac_unit_vert_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset, in_valid, in_ready, load_accum;
    logic [15:0][7:0]     act_in;
    logic [19:0]          accum_prev, accum_out;
    logic                 col_valid, col_ready, out_valid, out_ready;
    logic [7:0][2:0]      act_sel;
    logic [7:0]           act_val;
    logic [1:0]           skip;
    logic [15:0]          result;

    int n_chk = 0;
    int n_err = 0;

    mac_unit_vert_seq dut (
        .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_act_in(act_in), .i_load_accum(load_accum), .i_accum_prev(accum_prev),
        .i_col_valid(col_valid), .o_col_ready(col_ready), .i_act_sel(act_sel),
        .i_act_val(act_val), .i_is_skip_zero(skip), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_result(result), .o_accum_out(accum_out)
    );

    typedef struct {
        logic signed [7:0] a0;
        logic signed [7:0] step;
        logic              ld;
        logic [19:0]       prev;
        logic [7:0][7:0]   val;
        logic [7:0][2:0]   sel;
        logic [7:0][1:0]   skp;
        logic              gap;
        logic [19:0]       exp;
    } vec_t;

    vec_t tv[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
        end
    endtask

    function automatic logic [15:0] res_of(input logic [19:0] acc);
`ifdef MAC_VERT_SEQ_ROUND_EN
        longint v;
        v = (longint'(signed'(acc)) + 8) >>> 4;
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return v[15:0];
`else
        return acc[19:4];
`endif
    endfunction

    function automatic vec_t zvec();
        vec_t v;
        v.a0 = 0; v.step = 0; v.ld = 0; v.prev = 0;
        v.val = '0; v.sel = '0; v.skp = {8{2'b11}};
        v.gap = 0; v.exp = 0;
        return v;
    endfunction

    task automatic run(input vec_t v, input string nm, input int abort_at);
        int cyc;
        int col;
        logic hs;
        bit gapped;
        for (int i = 0; i < 16; i++) act_in[i] = 8'(int'(v.a0) + i * int'(v.step));
        load_accum = v.ld;
        accum_prev = v.prev;
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 1; col = 0; gapped = 0;
        while (!out_valid && cyc < 200) begin
            if (abort_at >= 0 && col == abort_at) begin
                reset = 1'b1; col_valid = 1'b0;
                tick();
                reset = 1'b0;
                return;
            end
            if (v.gap && (col % 2 == 1) && !gapped) begin
                col_valid = 1'b0;
                gapped = 1;
            end else begin
                col_valid = (col < 8);
                if (col < 8) begin
                    act_val = v.val[col];
                    act_sel = {8{v.sel[col]}};
                    skip    = v.skp[col];
                end
            end
            hs = col_valid & col_ready;
            tick();
            cyc++;
            if (hs) begin col++; gapped = 0; end
        end
        col_valid = 1'b0;
        chk({nm, "_latency"}, 32'(cyc), v.gap ? 32'd14 : 32'd10);
        chk({nm, "_accum"}, 32'(accum_out), 32'(v.exp));
        chk({nm, "_result"}, 32'(result), 32'(res_of(v.exp)));
        chk({nm, "_col_ready_done"}, 32'(col_ready), 32'd0);
    endtask

    task automatic finish_out(input string nm);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, "_in_ready_after"}, 32'(in_ready), 32'd1);
        chk({nm, "_out_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset = 1; in_valid = 0; load_accum = 0; act_in = '0; accum_prev = '0;
        col_valid = 0; act_sel = '0; act_val = '0; skip = '0; out_ready = 0;
        tick(); tick();
        reset = 0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_col_ready", 32'(col_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_accum", 32'(accum_out), 32'd0);

        tv[0] = zvec(); tv[0].a0 = 3; tv[0].val[0] = 8'hFF; tv[0].exp = 20'd24;
        tv[1] = zvec(); tv[1].a0 = 3; tv[1].skp[7] = 2'b00; tv[1].exp = 20'hFE800;
        tv[2] = zvec(); tv[2].ld = 1; tv[2].prev = 20'd100; tv[2].gap = 1; tv[2].exp = 20'd100;
        tv[3] = zvec(); tv[3].a0 = -8; tv[3].step = 1; tv[3].ld = 1; tv[3].prev = 20'(-1000);
        tv[3].val[0] = 8'hFF; tv[3].sel[0] = 3'd1;
        tv[3].val[1] = 8'hFF; tv[3].sel[1] = 3'd4;
        tv[3].val[2] = 8'hFF; tv[3].sel[2] = 3'd5; tv[3].skp[2] = 2'b00;
        tv[3].val[3] = 8'h11; tv[3].skp[3] = 2'b01;
        tv[3].val[7] = 8'hFF;
        tv[3].exp = 20'd1700;
        tv[4] = zvec(); tv[4].a0 = -128; tv[4].skp[0] = 2'b00; tv[4].skp[7] = 2'b00;
        tv[4].exp = 20'h3F800;
        tv[5] = zvec(); tv[5].a0 = 1; tv[5].ld = 1; tv[5].prev = 20'h7FFFF;
        tv[5].val[0] = 8'h01; tv[5].exp = 20'h80000;
        tv[6] = zvec(); tv[6].ld = 1; tv[6].prev = 20'd24; tv[6].exp = 20'd24;
        tv[7] = zvec(); tv[7].ld = 1; tv[7].prev = 20'h7FFFF; tv[7].exp = 20'h7FFFF;

        for (int i = 0; i < 8; i++) begin
            run(tv[i], $sformatf("vec%0d", i), -1);
            finish_out($sformatf("vec%0d", i));
        end

        // Backpressure in DONE: output held, a second vector is not accepted.
        run(tv[0], "hold", -1);
        in_valid = 1'b1; load_accum = 1'b1; accum_prev = 20'd555;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_result", 32'(result), 32'd1);
            chk("hold_accum", 32'(accum_out), 32'd24);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        finish_out("hold");
        chk("hold_accum_idle", 32'(accum_out), 32'd24);

        // Reset after four columns discards the partial result.
        run(tv[3], "abort", 4);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_col_ready", 32'(col_ready), 32'd0);
        chk("abort_accum", 32'(accum_out), 32'd0);
        run(tv[0], "fresh", -1);
        finish_out("fresh");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
